dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//   Memory-side responder for the core's data port: accepts one load/store
//   request at a time over a valid/ready handshake and returns a response
//   after a programmable number of wait states.
//   Backed by an internal word-addressed RAM. Replaces the zero-latency data
//   memory so the datapath/controller can be exercised against realistic
//   memory timing.
// PARAMETERS
//   DEPTH_WORDS  64  RAM size in 32-bit words; power of two, >= 4
//   LATENCY      2   wait-state cycles between accept and access; 0..15
// PORTS
//   clk         in   1   clock, rising edge
//   reset       in   1   asynchronous, active-low reset
//   req_valid   in   1   core presents a request
//   req_ready   out  1   responder can accept a request this cycle
//   req_we      in   1   1 = store, 0 = load
//   req_addr    in   32  byte address (the core's aluout)
//   req_wdata   in   32  store data (the core's writedata)
//   resp_valid  out  1   response available
//   resp_ready  in   1   core accepts the response
//   resp_rdata  out  32  load data; 0 for stores and errors
//   resp_err    out  1   request was misaligned or out of range
// BEHAVIOUR
//   Reset (reset=0, asynchronous):
//     - state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0,
//       wait counter=0.
//     - RAM contents are NOT cleared.
//     - An in-flight request is dropped. A store not yet committed never
//       writes.
//   FSM states: IDLE, WAIT, RESP.
//     IDLE: req_ready=1.
//       - Accept when req_valid&&req_ready at edge T; latch we/addr/wdata.
//       - LATENCY>0: go to WAIT, counter=LATENCY-1.
//       - LATENCY==0: perform the access at edge T, go to RESP.
//     WAIT: req_ready=0. Decrement the counter each cycle.
//       - When the counter==0, perform the access on that edge and go to RESP.
//     RESP: resp_valid=1; rdata/err held stable until handshake.
//       - On resp_valid&&resp_ready: go to IDLE. req_ready=1 the next cycle.
//       - No request is accepted in the same cycle as the response handshake.
//   Timing: accept at edge T -> resp_valid high from cycle T+LATENCY+1.
//     Minimum spacing between accepts is LATENCY+2 cycles.
//   Access:
//     - Word index = latched addr[log2(DEPTH_WORDS)+1:2].
//     - err = (addr[1:0]!=0) || (addr >= DEPTH_WORDS*4).
//     - err: no RAM write; resp_rdata=0; resp_err=1.
//     - Store without err: RAM[idx]=wdata at the access edge; resp_rdata=0.
//     - Load without err: resp_rdata=RAM[idx] as of the access edge.
//       A store responded earlier is always visible.
//   Request inputs are ignored while req_ready=0. The latched copy is used.
//   resp_ready asserted while resp_valid=0 has no effect.
//   Reset asserted mid-WAIT or mid-RESP: return to IDLE immediately.
//     A store whose access edge already occurred stays written.
// TESTING
//   1. LATENCY=2: store addr 0x10, data 0xDEADBEEF, accepted at edge 0
//      -> resp_valid at cycle 3, err=0, rdata=0. Then load 0x10
//      -> rdata=0xDEADBEEF.
//   2. Load addr 0x13 (misaligned) -> resp_err=1, rdata=0.
//      Store to 0x100 with DEPTH_WORDS=64 -> err=1; a later load of 0x0
//      is unchanged.
//   3. Hold resp_ready=0 for 5 cycles -> resp_valid, rdata and err stay
//      stable and req_ready=0; after the handshake, req_ready=1 the next cycle.
//   4. LATENCY=0: back-to-back store 0x4=0x1234 then load 0x4
//      -> responses at T+1 each, rdata=0x00001234, spacing 2 cycles.
//   5. Store 0x8=0xAAAA0000 accepted, then reset=0 during WAIT
//      -> outputs return to reset values at once; a load of 0x8 after reset
//      returns the old value.
//   6. Store addr 0xFC (last word) =0x5A5A5A5A, then load 0xFC
//      -> data matches; load 0x0 is unaffected.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-port memory responder: one load/store at a time, fixed wait states,
// response held on a valid/ready handshake. Backed by a word-addressed RAM.
//
// state | meaning
// IDLE  | ready for a request (req_ready=1)
// WAIT  | request latched, counting down wait states
// RESP  | response presented until resp_ready
module dmem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          lat_we_q;
    logic [31:0]   lat_addr_q;
    logic [31:0]   lat_wdata_q;
    logic [31:0]   rdata_q;
    logic          err_q;
    logic [31:0]   mem [DEPTH_WORDS];

    logic          accept;
    logic          access;
    logic          acc_we;
    logic [31:0]   acc_addr;
    logic [31:0]   acc_wdata;
    logic          acc_err;
    logic [AW-1:0] acc_idx;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        access  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (LATENCY == 0) begin
                        access  = 1'b1;
                        state_d = RESP;
                    end else begin
                        cnt_d   = LAT_M1;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    access  = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // With zero wait states the access happens on the accept edge, so it
    // must use the live request rather than the latched copy.
    assign acc_we    = (state_q == IDLE) ? req_we    : lat_we_q;
    assign acc_addr  = (state_q == IDLE) ? req_addr  : lat_addr_q;
    assign acc_wdata = (state_q == IDLE) ? req_wdata : lat_wdata_q;
    assign acc_err   = (|acc_addr[1:0]) || (|acc_addr[31:AW+2]);
    assign acc_idx   = acc_addr[AW+1:2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            lat_we_q    <= 1'b0;
            lat_addr_q  <= 32'd0;
            lat_wdata_q <= 32'd0;
            rdata_q     <= 32'd0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                lat_we_q    <= req_we;
                lat_addr_q  <= req_addr;
                lat_wdata_q <= req_wdata;
            end
            if (access) begin
                err_q   <= acc_err;
                rdata_q <= (acc_err || acc_we) ? 32'd0 : mem[acc_idx];
            end
        end
    end

    // RAM survives reset; reset forces IDLE so no pending store can commit.
    always_ff @(posedge clk) begin
        if (access && acc_we && !acc_err) mem[acc_idx] <= acc_wdata;
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance with two wait states, one with none,
// checked against a flat array model of the RAM and the access rules.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_we, resp_ready;
    logic [31:0] req_addr, req_wdata;
    bit          sel;

    logic        rv2, rr2, ready2, valid2, err2;
    logic [31:0] rdata2;
    logic        rv0, rr0, ready0, valid0, err0;
    logic [31:0] rdata0;

    logic        cur_ready, cur_valid, cur_err;
    logic [31:0] cur_rdata;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          acc_cyc;
    logic [31:0] mdl [2][64];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign rv2 = req_valid && !sel;
    assign rr2 = resp_ready && !sel;
    assign rv0 = req_valid && sel;
    assign rr0 = resp_ready && sel;

    assign cur_ready = sel ? ready0 : ready2;
    assign cur_valid = sel ? valid0 : valid2;
    assign cur_err   = sel ? err0   : err2;
    assign cur_rdata = sel ? rdata0 : rdata2;

    dmem_responder #(.DEPTH_WORDS(64), .LATENCY(2)) dut2 (
        .clk(clk), .reset(reset),
        .req_valid(rv2), .req_ready(ready2), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(valid2), .resp_ready(rr2),
        .resp_rdata(rdata2), .resp_err(err2)
    );

    dmem_responder #(.DEPTH_WORDS(64), .LATENCY(0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(rv0), .req_ready(ready0), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(valid0), .resp_ready(rr0),
        .resp_rdata(rdata0), .resp_err(err0)
    );

    typedef struct {
        bit          s;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wd;
        int          hold;
        logic [31:0] rd;
        bit          err;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Applies a request to the RAM model; returns the response it should produce.
    task automatic model_apply(input bit s, input bit we, input logic [31:0] addr,
                               input logic [31:0] wd, output logic [31:0] rd, output bit err);
        err = (addr % 4 != 0) || (addr >= 32'd256);
        rd  = 32'd0;
        if (!err) begin
            if (we) mdl[s][addr / 4] = wd;
            else    rd = mdl[s][addr / 4];
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with it idle again.
    task automatic txn(input bit s, input bit we, input logic [31:0] addr, input logic [31:0] wd,
                       input int hold, input logic [31:0] exp_rd, input bit exp_err);
        int n;
        int lat;
        lat = s ? 0 : 2;
        sel = s;
        #1;
        chk("ready_idle", 32'(cur_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        acc_cyc   = cyc;
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        n = 0;
        while (!cur_valid && n < 40) begin
            chk("wait_ready", 32'(cur_ready), 32'd0);
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        chk("latency", 32'(n), 32'(lat));
        chk("rdata", cur_rdata, exp_rd);
        chk("err", 32'(cur_err), 32'(exp_err));
        chk("resp_ready_low", 32'(cur_ready), 32'd0);
        resp_ready = 1'b0;
        req_we     = 1'b0;
        req_valid  = (hold > 0);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_valid", 32'(cur_valid), 32'd1);
            chk("hold_rdata", cur_rdata, exp_rd);
            chk("hold_err", 32'(cur_err), 32'(exp_err));
            chk("hold_ready", 32'(cur_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        req_valid  = 1'b0;
        chk("post_valid", 32'(cur_valid), 32'd0);
        chk("post_ready", 32'(cur_ready), 32'd1);
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_ready2"}, 32'(ready2), 32'd1);
        chk({nm, "_valid2"}, 32'(valid2), 32'd0);
        chk({nm, "_rdata2"}, rdata2, 32'd0);
        chk({nm, "_err2"}, 32'(err2), 32'd0);
        chk({nm, "_ready0"}, 32'(ready0), 32'd1);
        chk({nm, "_valid0"}, 32'(valid0), 32'd0);
        chk({nm, "_rdata0"}, rdata0, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] erd, v, a, a0;
        bit          eerr;
        int          r, n;

        sel = 0; reset = 1'b0; req_valid = 0; req_we = 0;
        req_addr = 0; req_wdata = 0; resp_ready = 0;
        repeat (3) @(negedge clk);
        chk_reset_vals("por");
        reset = 1'b1;
        @(negedge clk);

        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 64; i++) begin
                v = $urandom;
                model_apply(s[0], 1'b1, 32'(i * 4), v, erd, eerr);
                txn(s[0], 1'b1, 32'(i * 4), v, 0, erd, eerr);
            end
        end

        tbl[0]  = '{0, 1, 32'h0000_0000, 32'h1111_1111, 0, 32'h0, 0};
        tbl[1]  = '{0, 1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'h0, 0};
        tbl[2]  = '{0, 0, 32'h0000_0010, 32'h0,         0, 32'hDEAD_BEEF, 0};
        tbl[3]  = '{0, 0, 32'h0000_0013, 32'h0,         0, 32'h0, 1};
        tbl[4]  = '{0, 1, 32'h0000_0100, 32'hCAFE_F00D, 0, 32'h0, 1};
        tbl[5]  = '{0, 0, 32'h0000_0000, 32'h0,         0, 32'h1111_1111, 0};
        tbl[6]  = '{0, 0, 32'h0000_0010, 32'h0,         5, 32'hDEAD_BEEF, 0};
        tbl[7]  = '{0, 1, 32'h0000_00FC, 32'h5A5A_5A5A, 0, 32'h0, 0};
        tbl[8]  = '{0, 0, 32'h0000_00FC, 32'h0,         0, 32'h5A5A_5A5A, 0};
        tbl[9]  = '{0, 0, 32'h0000_0000, 32'h0,         2, 32'h1111_1111, 0};
        tbl[10] = '{1, 1, 32'h0000_0102, 32'h7777_7777, 0, 32'h0, 1};
        tbl[11] = '{1, 0, 32'h0000_0003, 32'h0,         3, 32'h0, 1};
        for (int i = 0; i < 12; i++) begin
            model_apply(tbl[i].s, tbl[i].we, tbl[i].addr, tbl[i].wd, erd, eerr);
            txn(tbl[i].s, tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].hold, tbl[i].rd, tbl[i].err);
        end

        // Zero-latency back-to-back store/load and accept spacing.
        model_apply(1'b1, 1'b1, 32'h4, 32'h1234, erd, eerr);
        txn(1'b1, 1'b1, 32'h4, 32'h1234, 0, 32'h0, 1'b0);
        a0 = 32'(acc_cyc);
        model_apply(1'b1, 1'b0, 32'h4, 32'h0, erd, eerr);
        txn(1'b1, 1'b0, 32'h4, 32'h0, 0, 32'h0000_1234, 1'b0);
        chk("spacing_lat0", 32'(acc_cyc) - a0, 32'd2);
        model_apply(1'b0, 1'b0, 32'h10, 32'h0, erd, eerr);
        txn(1'b0, 1'b0, 32'h10, 32'h0, 0, erd, eerr);
        a0 = 32'(acc_cyc);
        txn(1'b0, 1'b0, 32'h10, 32'h0, 0, erd, eerr);
        chk("spacing_lat2", 32'(acc_cyc) - a0, 32'd4);

        // Reset during WAIT: the store never commits.
        sel = 0;
        req_valid = 1; req_we = 1; req_addr = 32'h8; req_wdata = 32'hAAAA_0000;
        @(posedge clk);
        @(negedge clk);
        req_valid = 0;
        chk("wait_state_valid", 32'(valid2), 32'd0);
        #2 reset = 1'b0;
        #1 chk_reset_vals("rst_wait");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        model_apply(1'b0, 1'b0, 32'h8, 32'h0, erd, eerr);
        txn(1'b0, 1'b0, 32'h8, 32'h0, 0, erd, eerr);

        // Reset during RESP: the store already committed.
        sel = 0;
        req_valid = 1; req_we = 1; req_addr = 32'h8; req_wdata = 32'hBBBB_1111;
        @(posedge clk);
        @(negedge clk);
        req_valid = 0;
        n = 0;
        while (!valid2 && n < 40) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        chk("rst_resp_reached", 32'(valid2), 32'd1);
        #2 reset = 1'b0;
        #1 chk_reset_vals("rst_resp");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        mdl[0][2] = 32'hBBBB_1111;
        txn(1'b0, 1'b0, 32'h8, 32'h0, 0, 32'hBBBB_1111, 1'b0);

        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 9);
            a = {22'd0, 6'($urandom_range(0, 63)), 2'b00};
            if (r == 7) a = a + 32'($urandom_range(1, 3));
            else if (r == 8) a = 32'($urandom_range(64, 1023)) * 4;
            else if (r == 9) a = $urandom;
            v = $urandom;
            model_apply(1'($urandom), 1'b0, 32'h1, 32'h0, erd, eerr);
            sel = 1'($urandom);
            r = $urandom_range(0, 1);
            model_apply(sel, r[0], a, v, erd, eerr);
            txn(sel, r[0], a, v, $urandom_range(0, 3), erd, eerr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
